pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: scoreboard entry,
// forward-select encoding and default parameter values.
package cpu_pipe_pkg;

    localparam int unsigned DEF_STAGES   = 3;
    localparam int unsigned DEF_LOAD_LAT = 1;
    localparam int unsigned DEF_REG_AW   = 5;

    // Widest register index the scoreboard entry can carry; REG_AW must not exceed it.
    localparam int unsigned SB_RD_W = 8;

    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_write;
        logic               is_load;
    } sb_entry_t;

    // Matches in the oldest slot are covered by regfile write-through.
    function automatic int unsigned fwd_code(input int unsigned slot, input int unsigned stages);
        return (slot < stages - 1) ? slot + 1 : FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle between the pipeline and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned REG_AW = DEF_REG_AW
);
    localparam int unsigned SW = $clog2(STAGES);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              mdu_busy;

    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              stall_ex;
    logic              flush_ifid;
    logic              flush_idex;
    logic [SW-1:0]     fwd_sel_a;
    logic [SW-1:0]     fwd_sel_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, ex_branch_taken, mdu_busy,
        input  stall_if, stall_id, bubble_ex, stall_ex, flush_ifid, flush_idex,
               fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, ex_branch_taken, mdu_busy,
        output stall_if, stall_id, bubble_ex, stall_ex, flush_ifid, flush_idex,
               fwd_sel_a, fwd_sel_b
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: per-stage record of in-flight destinations, slot 0 = EX, slot STAGES-1 = WB.
module hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    freeze_ex,
    input  logic                    load_id,
    input  sb_entry_t               id_entry,
    output sb_entry_t [STAGES-1:0]  slots
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else begin
            for (int unsigned j = 2; j < STAGES; j++) begin
                slots[j] <= slots[j-1];
            end
            // A busy EX keeps its occupant; the stage behind it drains as a bubble.
            if (freeze_ex) begin
                slots[1] <= '0;
            end else begin
                slots[1] <= slots[0];
                slots[0] <= load_id ? id_entry : '0;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / multi-cycle hazard control with EX operand forwarding select.
// Optional PIPE_HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned STAGES   = DEF_STAGES,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned REG_AW   = DEF_REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    localparam int unsigned SW = $clog2(STAGES);

    sb_entry_t [STAGES-1:0] slots;
    sb_entry_t              id_entry;
    logic                   hazard;
    logic                   branch;
    logic                   busy;
    logic                   ld_stall;
    logic                   advance;
    logic [SW-1:0]          sel_a_d;
    logic [SW-1:0]          sel_b_d;
    logic [SW-1:0]          sel_a_q;
    logic [SW-1:0]          sel_b_q;

    function automatic logic slot_match(input sb_entry_t e, input logic [REG_AW-1:0] rs,
                                        input logic used);
        return used && (rs != '0) && e.valid && e.reg_write && (e.rd == SB_RD_W'(rs));
    endfunction

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = hz.id_valid;
        id_entry.rd        = SB_RD_W'(hz.id_rd);
        id_entry.reg_write = hz.id_reg_write;
        id_entry.is_load   = hz.id_is_load;
    end

    // Walk oldest to youngest so the youngest match is the one left in sel_*_d.
    always_comb begin
        hazard  = 1'b0;
        sel_a_d = SW'(FWD_RF);
        sel_b_d = SW'(FWD_RF);
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (slot_match(slots[STAGES-1-i], hz.id_rs1, hz.id_rs1_used)) begin
                sel_a_d = SW'(fwd_code(STAGES - 1 - i, STAGES));
                if (slots[STAGES-1-i].is_load && (STAGES - 1 - i) < LOAD_LAT) hazard = 1'b1;
            end
            if (slot_match(slots[STAGES-1-i], hz.id_rs2, hz.id_rs2_used)) begin
                sel_b_d = SW'(fwd_code(STAGES - 1 - i, STAGES));
                if (slots[STAGES-1-i].is_load && (STAGES - 1 - i) < LOAD_LAT) hazard = 1'b1;
            end
        end
        hazard = hazard & hz.id_valid;
    end

    // Priority: taken branch > multi-cycle busy > load-use; everything quiet in reset.
    assign branch   = rst_n & hz.ex_branch_taken;
    assign busy     = rst_n & hz.mdu_busy & ~hz.ex_branch_taken;
    assign ld_stall = rst_n & hazard & ~busy & ~branch;
    assign advance  = ~busy & ~ld_stall & ~branch;

    assign hz.stall_if   = busy | ld_stall;
    assign hz.stall_id   = busy | ld_stall;
    assign hz.stall_ex   = busy;
    assign hz.bubble_ex  = ld_stall;
    assign hz.flush_ifid = branch;
    assign hz.flush_idex = branch;
    assign hz.fwd_sel_a  = sel_a_q;
    assign hz.fwd_sel_b  = sel_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_q <= SW'(FWD_RF);
            sel_b_q <= SW'(FWD_RF);
        end else if (advance) begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    hazard_scoreboard #(.STAGES(STAGES)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze_ex (busy),
        .load_id   (advance),
        .id_entry  (id_entry),
        .slots     (slots)
    );

`ifdef PIPE_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (hz.flush_idex && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

    a_no_branch_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(hz.mdu_busy && hz.ex_branch_taken));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl against an instruction-queue reference model.
module tb_pipe_hazard_ctrl;
    import cpu_pipe_pkg::*;

    localparam int STAGES   = 3;
    localparam int LOAD_LAT = 1;
    localparam int REG_AW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAGES(STAGES), .REG_AW(REG_AW)) hz ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(.STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Reference model: instructions in flight, each tagged with its distance past EX.
    typedef struct { int pos; int rd; bit rw; bit ld; } instr_t;
    instr_t inflight[$];
    int m_sel_a, m_sel_b;
    int m_stall_cnt, m_flush_cnt;
    int vectors, miscompares;
    logic o_stall_id, o_bubble, o_stall_ex, o_flush;

    function automatic int youngest_src(input int rs, input bit used);
        int best;
        best = -1;
        if (!used || rs == 0) return 0;
        foreach (inflight[i])
            if (inflight[i].rw && inflight[i].rd == rs && (best < 0 || inflight[i].pos < best))
                best = inflight[i].pos;
        if (best < 0 || best == STAGES - 1) return 0;
        return best + 1;
    endfunction

    function automatic bit load_pending(input int rs, input bit used);
        if (!used || rs == 0) return 1'b0;
        foreach (inflight[i])
            if (inflight[i].rw && inflight[i].ld && inflight[i].rd == rs && inflight[i].pos < LOAD_LAT)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit br, input bit busy);
        hz.id_valid        = v;
        hz.id_rs1          = REG_AW'(rs1);
        hz.id_rs1_used     = u1;
        hz.id_rs2          = REG_AW'(rs2);
        hz.id_rs2_used     = u2;
        hz.id_rd           = REG_AW'(rd);
        hz.id_reg_write    = rw;
        hz.id_is_load      = ld;
        hz.ex_branch_taken = br;
        hz.mdu_busy        = busy;
    endtask

    // One clock: drive at edge+1, compare at the falling edge, advance the model on the next edge.
    task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit br, input bit busy);
        bit haz, e_stall, e_bub, e_sex, e_fl;
        int na, nb;
        drive(v, rs1, u1, rs2, u2, rd, rw, ld, br, busy);
        haz   = v && (load_pending(rs1, u1) || load_pending(rs2, u2));
        e_fl  = br;
        e_sex = busy && !br;
        e_bub = haz && !busy && !br;
        e_stall = e_sex || e_bub;
        na = youngest_src(rs1, u1);
        nb = youngest_src(rs2, u2);
        #4;
        o_stall_id = hz.stall_id;
        o_bubble   = hz.bubble_ex;
        o_stall_ex = hz.stall_ex;
        o_flush    = hz.flush_idex;
        check("stall_if",   32'(hz.stall_if),   32'(e_stall));
        check("stall_id",   32'(hz.stall_id),   32'(e_stall));
        check("stall_ex",   32'(hz.stall_ex),   32'(e_sex));
        check("bubble_ex",  32'(hz.bubble_ex),  32'(e_bub));
        check("flush_ifid", 32'(hz.flush_ifid), 32'(e_fl));
        check("flush_idex", 32'(hz.flush_idex), 32'(e_fl));
        check("fwd_sel_a",  32'(hz.fwd_sel_a),  32'(m_sel_a));
        check("fwd_sel_b",  32'(hz.fwd_sel_b),  32'(m_sel_b));
        @(posedge clk);
        if (e_stall) m_stall_cnt++;
        if (e_fl) m_flush_cnt++;
        foreach (inflight[i])
            if (!(e_sex && inflight[i].pos == 0)) inflight[i].pos++;
        for (int i = inflight.size() - 1; i >= 0; i--)
            if (inflight[i].pos >= STAGES) inflight.delete(i);
        if (!e_stall && !br) begin
            m_sel_a = na;
            m_sel_b = nb;
            if (v) inflight.push_back('{pos: 0, rd: rd, rw: rw, ld: ld});
        end
        #1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_if"},  32'(hz.stall_if),   0);
        check({tag, "_stall_id"},  32'(hz.stall_id),   0);
        check({tag, "_stall_ex"},  32'(hz.stall_ex),   0);
        check({tag, "_bubble"},    32'(hz.bubble_ex),  0);
        check({tag, "_flush_ifid"},32'(hz.flush_ifid), 0);
        check({tag, "_flush_idex"},32'(hz.flush_idex), 0);
        check({tag, "_sel_a"},     32'(hz.fwd_sel_a),  0);
        check({tag, "_sel_b"},     32'(hz.fwd_sel_b),  0);
    endtask

    task automatic model_reset();
        inflight.delete();
        m_sel_a = 0; m_sel_b = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // Reset must mask even a branch and a live load-use request.
        drive(1, 7, 1, 7, 1, 7, 1, 1, 1, 0);
        #1;
        check_all_zero("reset");
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD x5 ; ADD x6,x5,x5 : forwarded from EX+1, no stall.
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
        step(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("r25_stall", 32'(o_stall_id), 0);
        check("r25_sel_a", 32'(hz.fwd_sel_a), 1);
        check("r25_sel_b", 32'(hz.fwd_sel_b), 1);
        nop(); nop(); nop();

        // LW x7 ; ADD x8,x7,x0 : one bubble then forward from EX+2.
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        check("r26_stall1", 32'(o_stall_id), 1);
        check("r26_bubble1", 32'(o_bubble), 1);
        step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        check("r26_stall2", 32'(o_stall_id), 0);
        check("r26_sel_a", 32'(hz.fwd_sel_a), 2);
        check("r26_sel_b", 32'(hz.fwd_sel_b), 0);
        nop(); nop(); nop();

        // LW x7 then taken branch coinciding with the load-use hazard.
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 0, 1, 8, 1, 0, 1, 0);
        check("r27_flush", 32'(o_flush), 1);
        check("r27_stall", 32'(o_stall_id), 0);
        check("r27_bubble", 32'(o_bubble), 0);
        nop(); nop(); nop();

        // Writes to x0 never forward; two x9 producers, youngest wins.
        step(1, 1, 1, 2, 1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        check("r28_x0_stall", 32'(o_stall_id), 0);
        check("r28_x0_sel_a", 32'(hz.fwd_sel_a), 0);
        step(1, 1, 1, 2, 1, 9, 1, 0, 0, 0);
        step(1, 1, 1, 2, 1, 9, 1, 0, 0, 0);
        step(1, 9, 1, 9, 1, 4, 1, 0, 0, 0);
        check("r28_young_a", 32'(hz.fwd_sel_a), 1);
        check("r28_young_b", 32'(hz.fwd_sel_b), 1);
        nop(); nop(); nop();

        // LW x7 ; ADD x10 ; four busy cycles; then a reader of x10 and x7.
        step(1, 1, 1, 2, 1, 7, 1, 1, 0, 0);
        step(1, 1, 1, 2, 1, 10, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 10, 1, 7, 1, 11, 1, 0, 0, 1);
            check("r29_stall_ex", 32'(o_stall_ex), 1);
            check("r29_sel_held", 32'(hz.fwd_sel_a), 0);
        end
        step(1, 10, 1, 7, 1, 11, 1, 0, 0, 0);
        check("r29_after_stall", 32'(o_stall_id), 0);
        check("r29_ex_frozen", 32'(hz.fwd_sel_a), 1);
        check("r29_load_retired", 32'(hz.fwd_sel_b), 0);
        nop(); nop(); nop();

        // Same setup with reset pulsed during the second busy cycle.
        step(1, 1, 1, 2, 1, 7, 1, 1, 0, 0);
        step(1, 1, 1, 2, 1, 10, 1, 0, 0, 0);
        step(1, 10, 1, 7, 1, 11, 1, 0, 0, 1);
        drive(1, 10, 1, 7, 1, 11, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #2;
        check_all_zero("r29_rst");
        @(posedge clk); #1;
        check_all_zero("r29_rst_edge");
        rst_n = 1'b1;
        model_reset();
        step(1, 10, 1, 7, 1, 11, 1, 0, 0, 0);
        check("r29_empty_stall", 32'(o_stall_id), 0);
        check("r29_empty_sel_a", 32'(hz.fwd_sel_a), 0);

        // Counters restarted at reset: 3 load-use stalls and 2 flushes.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0, 12, 1, 1, 0, 0);
            step(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
            step(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
        end
        step(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
        step(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("r30_stall_cnt", stall_cnt, 3);
        check("r30_flush_cnt", flush_cnt, 2);
`endif

        // Random traffic over a small register set to provoke frequent matches.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step(($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 (r == 0), (r == 1));
        end
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("rand_stall_cnt", stall_cnt, 32'(m_stall_cnt));
        check("rand_flush_cnt", flush_cnt, 32'(m_flush_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
